// File: rtl/instr_encoder.sv
// instr_encoder: encodes one instruction request at a time into a 32-bit
// word and writes it to consecutive instruction-memory addresses. The
// IDLE -> WRITE -> IDLE handshake limits throughput to one word every two
// cycles. The block parks in FULL after address 1023 has been written.
module instr_encoder (
  input  logic        clk,
  input  logic        reset,
  input  logic        In_valid,
  output logic        In_ready,
  input  logic [2:0]  Op_class,
  input  logic [4:0]  Rd,
  input  logic [4:0]  Rs1,
  input  logic [4:0]  Rs2,
  input  logic [2:0]  Funct3,
  input  logic [6:0]  Funct7,
  input  logic [11:0] Imm,
  input  logic        Clear,
  output logic        Imem_we,
  output logic [9:0]  Imem_addr,
  output logic [31:0] Imem_wdata,
  output logic [10:0] Count,
  output logic        Err
);

  typedef enum logic [1:0] {IDLE, WRITE, FULL} state_t;

  state_t      state_q, state_d;
  logic [9:0]  addr_q, addr_d;
  logic [10:0] count_q, count_d;
  logic [31:0] wdata_q, wdata_d;
  logic        err_q, err_d;
  logic [31:0] enc;
  logic        legal;

  // Combinational encoder. Op_class values 5-7 produce no word and are flagged.
  always_comb begin
    enc   = '0;
    legal = 1'b1;
    case (Op_class)
      3'd0:    enc = {Funct7, Rs2, Rs1, Funct3, Rd, 7'b0110011};
      3'd1:    enc = {Imm, Rs1, Funct3, Rd, 7'b0010011};
      3'd2:    enc = {Imm, Rs1, Funct3, Rd, 7'b0000011};
      3'd3:    enc = {Imm[11:5], Rs2, Rs1, Funct3, Imm[4:0], 7'b0100011};
      3'd4:    enc = {Imm[11], Imm[9:4], Rs2, Rs1, Funct3, Imm[3:0], Imm[10], 7'b1100011};
      default: legal = 1'b0;
    endcase
  end

  // Next state and outputs. Clear overrides everything, including a pending write.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    count_d  = count_q;
    wdata_d  = wdata_q;
    err_d    = err_q;
    In_ready = (state_q == IDLE);
    Imem_we  = 1'b0;
    if (Clear) begin
      state_d = IDLE;
      addr_d  = '0;
      count_d = '0;
      err_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (In_valid) begin
            if (legal) begin
              wdata_d = enc;
              state_d = WRITE;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        WRITE: begin
          Imem_we = 1'b1;
          addr_d  = addr_q + 10'd1;
          count_d = count_q + 11'd1;
          state_d = (addr_q == 10'd1023) ? FULL : IDLE;
        end
        FULL:    state_d = FULL;
        default: state_d = IDLE;
      endcase
    end
  end

  // State registers. Reset is asynchronous, so a reset during WRITE suppresses that write at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      count_q <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      count_q <= count_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
    end
  end

  assign Imem_addr  = addr_q;
  assign Imem_wdata = wdata_q;
  assign Count      = count_q;
  assign Err        = err_q;

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-002 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-003 SHALL have port In_valid, input, 1, encode request valid.
REQ-004 SHALL have port In_ready, output, 1, request accepted when In_valid && In_ready at a rising edge.
REQ-005 SHALL have port Op_class, input, 3, 0=R-format, 1=Imm, 2=ld, 3=sd, 4=beq, 5-7=illegal.
REQ-006 SHALL have ports Rd, Rs1 and Rs2, input, 5 each, register fields.
REQ-007 SHALL have ports Funct3 (input, 3) and Funct7 (input, 7), function fields.
REQ-008 SHALL have port Imm, input, 12: immediate for Imm/ld/sd, branch offset bits [12:1] for beq.
REQ-009 SHALL have port Clear, input, 1, synchronous restart.
REQ-010 SHALL have ports Imem_we (output, 1), Imem_addr (output, 10, word address) and Imem_wdata (output, 32): instruction-memory write port.
REQ-011 SHALL have port Count, output, 11, number of words written since reset/Clear.
REQ-012 SHALL have port Err, output, 1, sticky illegal-Op_class flag.

Function
REQ-013 SHALL implement FSM states IDLE, WRITE and FULL; In_ready=1 only in IDLE.
REQ-014 IDLE with legal accepted request: SHALL register the encoded word and go to WRITE.
REQ-015 WRITE: SHALL assert Imem_we for exactly one cycle with registered Imem_wdata at current Imem_addr.
REQ-016 Leaving WRITE: SHALL increment Imem_addr and Count; next state FULL if the written address was 1023, else IDLE.
REQ-017 Latency/throughput: Imem_we SHALL assert the cycle after acceptance; at most one word per 2 cycles.
REQ-018 Illegal Op_class accepted: SHALL set Err, produce no write, leave Imem_addr and Count unchanged, and remain in IDLE.
REQ-019 R encoding SHALL be {Funct7,Rs2,Rs1,Funct3,Rd,7'b0110011}.
REQ-020 Imm encoding SHALL be {Imm,Rs1,Funct3,Rd,7'b0010011}.
REQ-021 ld encoding SHALL be {Imm,Rs1,Funct3,Rd,7'b0000011}.
REQ-022 sd encoding SHALL be {Imm[11:5],Rs2,Rs1,Funct3,Imm[4:0],7'b0100011}.
REQ-023 beq encoding SHALL be {Imm[11],Imm[9:4],Rs2,Rs1,Funct3,Imm[3:0],Imm[10],7'b1100011}.
REQ-024 FULL: In_ready=0, Imem_we=0, Imem_addr=0 (wrapped), Count=1024; SHALL hold until Clear or reset.
REQ-025 Clear SHALL take priority over all activity in any state: next cycle state IDLE, Imem_addr=0, Count=0, Err=0; a pending WRITE is aborted with no Imem_we.
REQ-026 In_valid && Clear in the same cycle: the request SHALL be dropped.
REQ-027 Inputs SHALL be sampled only at acceptance; changes while in WRITE/FULL SHALL have no effect.

Reset
REQ-028 reset SHALL immediately force state IDLE, In_ready=1, Imem_we=0, Imem_addr=0, Imem_wdata=0, Count=0, Err=0, independent of clk.
REQ-029 reset asserted during WRITE SHALL suppress that write.

Verification
REQ-030 R add: Op_class=0, Rd=3, Rs1=1, Rs2=2, Funct3=0, Funct7=0 -> next cycle Imem_we=1, addr 0, wdata 0x002081B3; then Count=1.
REQ-031 ld then sd: {2,Rd=5,Rs1=2,F3=3,Imm=8} -> 0x00813283 at addr 0; {3,Rs1=1,Rs2=2,F3=3,Imm=16} -> 0x0020B823 at addr 1.
REQ-032 beq: Op_class=4, Rs1=1, Rs2=2, Funct3=0, Imm=4 -> 0x00208463; Op_class=6 -> Err=1, no Imem_we, addr unchanged.
REQ-033 Fill: 1024 back-to-back legal requests -> last write at addr 1023, state FULL, In_ready=0, Count=1024; Clear -> Count=0, addr 0, In_ready=1.
REQ-034 Clear asserted in WRITE cycle -> no Imem_we, Count=0, Err=0; async reset mid-WRITE -> outputs zero before the next clock edge.
